// File: rtl/mul_sched_if.sv
// mul_sched_if: requester, multiplier and response signals of the multiplier scheduler.
// Latency: none; this file only groups wires.
// Backpressure: req_valid/req_ready per requester; rsp_valid has no backpressure.
interface mul_sched_if #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_LEN = 32
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*DATA_LEN-1:0] req_a;
  logic [NUM_REQ*DATA_LEN-1:0] req_b;
  logic [DATA_LEN-1:0]         mul_a;
  logic [DATA_LEN-1:0]         mul_b;
  logic [DATA_LEN-1:0]         mul_result;
  logic                        mul_reset;
  logic                        flush;
  logic                        rsp_valid;
  logic [ID_W-1:0]             rsp_id;
  logic [DATA_LEN-1:0]         rsp_result;
  logic                        busy;

  // Requesters plus the external multiplier: drives operands, flush and the product.
  modport master (
    output req_valid, req_a, req_b, mul_result, flush,
    input  req_ready, mul_a, mul_b, mul_reset, rsp_valid, rsp_id, rsp_result, busy
  );

  // The scheduler itself.
  modport slave (
    input  req_valid, req_a, req_b, mul_result, flush,
    output req_ready, mul_a, mul_b, mul_reset, rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

// File: rtl/mul_sched.sv
// mul_sched: round-robin scheduler sharing one pipelined multiplier among NUM_REQ requesters.
// Latency: PIPELINE_STAGE+1 cycles from the accepting edge to rsp_valid; one grant per cycle.
// Backpressure: combinational req_ready per requester, one op outstanding each; flush drops in-flight work.
module mul_sched #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_LEN       = 32,
  parameter int PIPELINE_STAGE = 2
) (
  input logic        clk,
  input logic        reset,
  mul_sched_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(PIPELINE_STAGE + 2);
  localparam logic [CNT_W-1:0] FLUSH_LEN = CNT_W'(PIPELINE_STAGE + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_flush_cnt;
  logic [ID_W-1:0]       r_rr_ptr;       // first index searched next cycle
  logic [NUM_REQ-1:0]    r_outstanding;

  logic                  w_run_ok;       // grants allowed this cycle
  logic                  w_clear;        // drop all in-flight work at the next edge
  logic [NUM_REQ-1:0]    w_eligible;
  logic                  w_grant_vld;
  logic [ID_W-1:0]       w_grant_id;
  logic [NUM_REQ-1:0]    w_grant_oh;
  logic [DATA_LEN-1:0]   w_sel_a;
  logic [DATA_LEN-1:0]   w_sel_b;

  // Tag riding alongside mul_a/mul_b, then a PIPELINE_STAGE-deep delay line
  // so the tail lines up with the cycle in which mul_result is valid.
  logic                  r_op_vld;
  logic [ID_W-1:0]       r_op_id;
  logic [PIPELINE_STAGE-1:0] r_tag_vld;
  logic [ID_W-1:0]       r_tag_id [PIPELINE_STAGE];
  logic                  w_rsp_fire;
  logic [ID_W-1:0]       w_tail_id;
  logic [NUM_REQ-1:0]    w_rsp_clr;

  logic [DATA_LEN-1:0]   r_mul_a;
  logic [DATA_LEN-1:0]   r_mul_b;
  logic                  r_rsp_vld;
  logic [ID_W-1:0]       r_rsp_id;
  logic [DATA_LEN-1:0]   r_rsp_result;
  logic                  w_mul_reset;
  logic                  w_busy;

  assign w_run_ok   = (r_state == ST_RUN) && !bus.flush;
  assign w_clear    = (r_state == ST_FLUSH) || bus.flush;
  assign w_eligible = w_run_ok ? (bus.req_valid & ~r_outstanding) : '0;
  assign w_tail_id  = r_tag_id[PIPELINE_STAGE-1];
  assign w_rsp_fire = r_tag_vld[PIPELINE_STAGE-1] && !w_clear;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: flush enters FLUSH, counter expiry returns to RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (bus.flush) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (!bus.flush && (r_flush_cnt == CNT_ONE)) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs: multiplier clear during FLUSH, busy while anything is in flight.
  always_comb begin
    w_mul_reset = (r_state == ST_FLUSH);
    w_busy      = (r_state == ST_FLUSH) || (|r_outstanding);
  end

  // FLUSH length counter; any flush pulse (re)loads the full length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush_cnt <= '0;
    end else if (bus.flush) begin
      r_flush_cnt <= FLUSH_LEN;
    end else if (r_state == ST_FLUSH) begin
      r_flush_cnt <= r_flush_cnt - CNT_ONE;
    end
  end

  // Round-robin search starting at r_rr_ptr among eligible requesters.
  always_comb begin
    logic [ID_W-1:0] idx;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_grant_vld && w_eligible[idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = idx;
      end
    end
  end

  // One-hot grant (also req_ready) and operand mux for the winner.
  always_comb begin
    w_grant_oh = '0;
    w_sel_a    = '0;
    w_sel_b    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant_vld && (w_grant_id == ID_W'(k))) begin
        w_grant_oh[k] = 1'b1;
        w_sel_a       = bus.req_a[k*DATA_LEN +: DATA_LEN];
        w_sel_b       = bus.req_b[k*DATA_LEN +: DATA_LEN];
      end
    end
  end

  // One-hot of the requester whose response is being registered this edge.
  always_comb begin
    w_rsp_clr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_rsp_fire && (w_tail_id == ID_W'(k))) w_rsp_clr[k] = 1'b1;
    end
  end

  // Round-robin pointer moves past the last grant; untouched by FLUSH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_grant_vld) begin
      r_rr_ptr <= (w_grant_id == LAST_ID) ? '0 : w_grant_id + ID_W'(1);
    end
  end

  // Outstanding bits: set on grant, cleared as the response is raised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outstanding <= '0;
    end else if (w_clear) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= (r_outstanding & ~w_rsp_clr) | w_grant_oh;
    end
  end

  // Multiplier operand registers and their tag; zero on idle cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_op_vld <= 1'b0;
      r_op_id  <= '0;
    end else begin
      r_mul_a  <= w_grant_vld ? w_sel_a : '0;
      r_mul_b  <= w_grant_vld ? w_sel_b : '0;
      r_op_vld <= w_grant_vld;
      r_op_id  <= w_grant_id;
    end
  end

  // Tag delay line matching the multiplier latency; wiped during flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_vld <= '0;
      for (int k = 0; k < PIPELINE_STAGE; k++) r_tag_id[k] <= '0;
    end else if (w_clear) begin
      r_tag_vld <= '0;
      for (int k = 0; k < PIPELINE_STAGE; k++) r_tag_id[k] <= '0;
    end else begin
      r_tag_vld[0] <= r_op_vld;
      r_tag_id[0]  <= r_op_id;
      for (int k = 1; k < PIPELINE_STAGE; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
    end
  end

  // Response registers: capture the product when the tag tail is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_vld    <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
    end else begin
      r_rsp_vld <= w_rsp_fire;
      if (w_rsp_fire) begin
        r_rsp_id     <= w_tail_id;
        r_rsp_result <= bus.mul_result;
      end
    end
  end

  assign bus.req_ready  = w_grant_oh;
  assign bus.mul_a      = r_mul_a;
  assign bus.mul_b      = r_mul_b;
  assign bus.mul_reset  = w_mul_reset;
  assign bus.rsp_valid  = r_rsp_vld;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.busy       = w_busy;
endmodule

// File: doc/mul_sched.md
MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one multiplier.
REQ-002 The block SHALL have parameter DATA_LEN, default 32, giving the operand and result width.
REQ-003 The block SHALL have parameter PIPELINE_STAGE, default 2, giving the multiplier latency in cycles (minimum 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the clock; all logic is on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester operand valid.
REQ-007 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester accept; a transfer occurs when valid and ready are both high.
REQ-008 The block SHALL have port req_a, input, NUM_REQ*DATA_LEN bits: operand a; requester i uses slice [i*DATA_LEN +: DATA_LEN].
REQ-009 The block SHALL have port req_b, input, NUM_REQ*DATA_LEN bits: operand b, sliced as req_a.
REQ-010 The block SHALL have port mul_a, output, DATA_LEN bits: registered multiplier operand a.
REQ-011 The block SHALL have port mul_b, output, DATA_LEN bits: registered multiplier operand b.
REQ-012 The block SHALL have port mul_result, input, DATA_LEN bits: multiplier result.
REQ-013 The block SHALL have port mul_reset, output, 1 bit: synchronous clear to the multiplier.
REQ-014 The block SHALL have port flush, input, 1 bit: single-cycle pulse that drops all in-flight work.
REQ-015 The block SHALL have port rsp_valid, output, 1 bit: result valid, one cycle, no backpressure.
REQ-016 The block SHALL have port rsp_id, output, clog2(NUM_REQ) bits: index of the requester that owns the result.
REQ-017 The block SHALL have port rsp_result, output, DATA_LEN bits: lower DATA_LEN bits of a*b.
REQ-018 The block SHALL have port busy, output, 1 bit: high while any operation is in flight or the block is in state FLUSH.

Function
REQ-019 Multiplier contract: operands registered on mul_a/mul_b in cycle t produce mul_result that is valid in cycle t+PIPELINE_STAGE; the multiplier is fully pipelined and accepts one operation per cycle.
REQ-020 The state machine SHALL have two states, RUN and FLUSH.
REQ-021 In RUN, at most one requester is granted per cycle, chosen round-robin; the search starts at the index after the last granted requester.
REQ-022 req_ready[i] SHALL be combinational and SHALL be high only when all of the following hold: state is RUN, flush is low, requester i is the round-robin winner among eligible valid requesters.
REQ-023 A requester is eligible only while it has no operation in flight; each requester has at most one outstanding operation.
REQ-024 On a grant to requester i, mul_a/mul_b SHALL register i's operands the next edge, and a tag {valid=1, id=i} SHALL enter a PIPELINE_STAGE-deep tag shift register.
REQ-025 On a cycle with no grant, mul_a/mul_b SHALL hold zero and the tag entering the shift register SHALL be invalid.
REQ-026 When the tag leaving the shift register is valid, rsp_valid/rsp_id/rsp_result SHALL be registered from it and mul_result.
REQ-027 Total latency from the accepting edge to rsp_valid high SHALL be PIPELINE_STAGE+1 cycles.
REQ-028 Requester i's outstanding bit SHALL clear on the edge that raises rsp_valid for id i; i SHALL be eligible again in that same cycle.
REQ-029 Back-to-back grants from different requesters SHALL sustain one result per cycle.
REQ-030 If flush is high in RUN, no grant SHALL occur that cycle and the state SHALL move to FLUSH.
REQ-031 FLUSH SHALL last exactly PIPELINE_STAGE+1 cycles, tracked by a down-counter. During FLUSH:
- mul_reset is high
- all tags and outstanding bits are cleared
- mul_a/mul_b are zero
- rsp_valid is low, including for results that were in flight
- req_ready is all zero
When the counter expires, the state SHALL return to RUN.
REQ-032 flush asserted while already in FLUSH SHALL restart the counter.
REQ-033 The round-robin pointer SHALL be preserved across FLUSH.

Reset
REQ-034 While reset is asserted, the block SHALL asynchronously force:
- state RUN; round-robin pointer to 0, so requester 0 has first priority
- all tags and outstanding bits cleared
- mul_a, mul_b, rsp_result, rsp_id to 0
- rsp_valid, busy, mul_reset to 0
REQ-035 The first grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-036 Single op: requester 0 sends a=6, b=7 -> rsp_valid with rsp_id=0 and rsp_result=42 exactly PIPELINE_STAGE+1 cycles later; busy is high throughout and low after.
REQ-037 Fairness: all 4 requesters valid continuously -> grants in order 0,1,2,3,0,...; each requester is regranted only after its own response; no requester is starved.
REQ-038 Wrap: a=0xFFFFFFFF, b=2 -> rsp_result=0xFFFFFFFE (low 32 bits only).
REQ-039 Flush mid-flight: grant requesters 1 and 2, then pulse flush one cycle later -> no rsp_valid for either; mul_reset high for PIPELINE_STAGE+1 cycles; req_ready resumes afterwards with the next grant going to requester 3.
REQ-040 Flush and request in the same cycle: requester 0 is valid while flush is high -> req_ready[0]=0; the operation is accepted only after FLUSH ends.
REQ-041 Reset mid-operation: assert reset with 2 operations in flight -> all outputs return to reset values immediately; no stale rsp_valid after reset is released.
